// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/dmem_word_array.sv
// DEPTH x 32 register array: async-low clear, byte-enabled registered write,
// combinational read at the same word index.
module dmem_word_array #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned IDX_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       be_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with valid/ready request and response
// handshakes, byte enables and misaligned/out-of-range error reporting.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CntLoad = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : gen_bad_latency
    $fatal(1, "dmem_responder: LATENCY must be within 1..15");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             enter_resp;

  logic             acc_write;
  logic [31:0]      acc_addr, acc_wdata, acc_idx;
  logic [3:0]       acc_be;
  logic             acc_err;
  logic             mem_we;
  logic [31:0]      mem_rdata;

  // With LATENCY=1 the accept edge is also the RESP-entry edge, so the access
  // must use the live request rather than the registered copy.
  always_comb begin
    if (state_q == StIdle) begin
      acc_write = req_write_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      acc_be    = req_be_i;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign acc_idx = {2'b00, acc_addr[31:2]};
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_idx >= DEPTH);
  assign mem_we  = enter_resp && acc_write && !acc_err;

  dmem_word_array #(
    .DEPTH (DEPTH),
    .IDX_W (IdxW)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .idx_i   (acc_addr[IdxW+1:2]),
    .wdata_i (acc_wdata),
    .be_i    (acc_be),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (LATENCY == 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_write) ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == StIdle && req_valid_i) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign busy_o      = (state_q != StIdle);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench: four responders (LATENCY 2,1,4,15) checked against an array-based
// memory model with directed and random transactions.
module tb_dmem_responder;

  localparam int unsigned Depth = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  rsp_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [3:0]  ready, valid, err, busy;
  logic [31:0] rdata [4];

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [4][Depth];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(Depth), .LATENCY(2)) u_dut_l2 (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid[0]), .req_ready_o(ready[0]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .rsp_valid_o(valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rdata[0]), .rsp_err_o(err[0]), .busy_o(busy[0]));
  dmem_responder #(.DEPTH(Depth), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid[1]), .req_ready_o(ready[1]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .rsp_valid_o(valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rdata[1]), .rsp_err_o(err[1]), .busy_o(busy[1]));
  dmem_responder #(.DEPTH(Depth), .LATENCY(4)) u_dut_l4 (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid[2]), .req_ready_o(ready[2]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .rsp_valid_o(valid[2]), .rsp_ready_i(rsp_ready[2]),
    .rsp_rdata_o(rdata[2]), .rsp_err_o(err[2]), .busy_o(busy[2]));
  dmem_responder #(.DEPTH(Depth), .LATENCY(15)) u_dut_l15 (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid[3]), .req_ready_o(ready[3]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .rsp_valid_o(valid[3]), .rsp_ready_i(rsp_ready[3]),
    .rsp_rdata_o(rdata[3]), .rsp_err_o(err[3]), .busy_o(busy[3]));

  function automatic int lat_of(input int d);
    case (d)
      0: return 2;
      1: return 1;
      2: return 4;
      default: return 15;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < int'(Depth); i++) mdl[d][i] = '0;
  endtask

  // One complete transaction on responder d; the model decides data and error.
  task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int stall, input bit hold);
    logic [31:0] idx, exp_rd, held_rd;
    logic        exp_err, held_err;
    int          k;
    idx     = a >> 2;
    exp_err = (a % 4 != 0) || (idx >= Depth);
    exp_rd  = '0;
    if (!exp_err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[d][idx[6:0]][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rd = mdl[d][idx[6:0]];
      end
    end
    @(negedge clk);
    req_write    = wr;
    req_addr     = a;
    req_wdata    = wd;
    req_be       = be;
    req_valid[d] = 1'b1;
    rsp_ready[d] = (stall == 0);
    chk("ready_in_idle", 32'(ready[d]), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) req_valid[d] = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!valid[d] && k < 40);
    chk("rsp_latency", k, lat_of(d));
    chk("busy_in_resp", 32'(busy[d]), 32'd1);
    chk("ready_in_resp", 32'(ready[d]), 32'd0);
    chk("rsp_err", 32'(err[d]), 32'(exp_err));
    chk("rsp_rdata", rdata[d], exp_rd);
    held_rd  = rdata[d];
    held_err = err[d];
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(valid[d]), 32'd1);
      chk("stall_ready", 32'(ready[d]), 32'd0);
      chk("stall_rdata", rdata[d], held_rd);
      chk("stall_err", 32'(err[d]), 32'(held_err));
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    chk("idle_valid", 32'(valid[d]), 32'd0);
    chk("idle_ready", 32'(ready[d]), 32'd1);
    chk("idle_busy", 32'(busy[d]), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk({tag, "_valid"}, 32'(valid[d]), 32'd0);
      chk({tag, "_err"}, 32'(err[d]), 32'd0);
      chk({tag, "_rdata"}, rdata[d], 32'd0);
      chk({tag, "_busy"}, 32'(busy[d]), 32'd0);
    end
  endtask

  initial begin
    bit          wr;
    int          d, sel, stall;
    logic [31:0] a;

    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    clear_model();
    #13;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) chk("reset_ready", 32'(ready[i]), 32'd1);

    // Full write then readback, partial write, errors.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'b1111, 0, 1'b0);
    txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'b1111, 0, 1'b0);
    txn(0, 1'b1, 32'h14, 32'h12345678, 4'b0000, 0, 1'b0);
    txn(0, 1'b0, 32'h14, 32'h0, 4'b1111, 0, 1'b0);
    txn(0, 1'b0, 32'h13, 32'h0, 4'b1111, 0, 1'b0);
    txn(0, 1'b1, 32'h200, 32'hFFFFFFFF, 4'b1111, 0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'b1111, 0, 1'b0);
    txn(0, 1'b0, 32'h1FC, 32'h0, 4'b1111, 0, 1'b0);

    // Backpressure with a request held during RESP, then accepted afterwards.
    txn(0, 1'b0, 32'h10, 32'h0, 4'b1111, 5, 1'b1);
    txn(0, 1'b1, 32'h18, 32'hCAFEF00D, 4'b1010, 0, 1'b0);
    txn(0, 1'b0, 32'h18, 32'h0, 4'b1111, 0, 1'b0);

    // Latency extremes.
    txn(1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'b1111, 0, 1'b0);
    txn(1, 1'b0, 32'h8, 32'h0, 4'b1111, 2, 1'b0);
    txn(3, 1'b1, 32'h8, 32'h5A5A5A5A, 4'b1100, 0, 1'b0);
    txn(3, 1'b0, 32'h8, 32'h0, 4'b1111, 1, 1'b0);

    // Reset in the second WAIT cycle of a LATENCY=4 write.
    txn(2, 1'b1, 32'h24, 32'h11223344, 4'b1111, 0, 1'b0);
    @(negedge clk);
    req_write    = 1'b1;
    req_addr     = 32'h20;
    req_wdata    = 32'h55;
    req_be       = 4'b1111;
    req_valid[2] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) chk("midrst_ready", 32'(ready[i]), 32'd1);
    txn(2, 1'b0, 32'h20, 32'h0, 4'b1111, 0, 1'b0);
    txn(2, 1'b0, 32'h24, 32'h0, 4'b1111, 0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'b1111, 0, 1'b0);

    // Random traffic across all four responders.
    for (int n = 0; n < 80; n++) begin
      d     = int'($urandom_range(0, 3));
      wr    = 1'($urandom_range(0, 1));
      sel   = int'($urandom_range(0, 9));
      stall = int'($urandom_range(0, 3));
      if (sel == 0) a = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
      else if (sel == 1) a = ($urandom_range(128, 200) * 4);
      else if (sel == 2) a = $urandom | 32'h8000_0000;
      else a = $urandom_range(0, 15) * 4;
      txn(d, wr, a, $urandom, 4'($urandom_range(0, 15)), stall, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL provide parameter DEPTH, default 128, meaning the number of 32-bit words stored.
REQ-002 SHALL provide parameter LATENCY, default 2, meaning the cycles from the request-accept edge to rsp_valid_o; the legal range is 1..15.
REQ-003 SHALL provide port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL provide port req_valid_i, input, 1 bit: the requester presents a request.
REQ-006 SHALL provide port req_ready_o, output, 1 bit: the responder can accept a request.
REQ-007 SHALL provide port req_write_i, input, 1 bit: 1 means write, 0 means read.
REQ-008 SHALL provide port req_addr_i, input, 32 bits: byte address.
REQ-009 SHALL provide port req_wdata_i, input, 32 bits: write data.
REQ-010 SHALL provide port req_be_i, input, 4 bits: byte enables; bit n controls byte lane n (bits 8n+7:8n).
REQ-011 SHALL provide port rsp_valid_o, output, 1 bit: a response is presented.
REQ-012 SHALL provide port rsp_ready_i, input, 1 bit: the requester accepts the response.
REQ-013 SHALL provide port rsp_rdata_o, output, 32 bits: read data.
REQ-014 SHALL provide port rsp_err_o, output, 1 bit: the request was misaligned or out of range.
REQ-015 SHALL provide port busy_o, output, 1 bit: a request is in flight; this is the pipeline stall source.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, WAIT and RESP.
REQ-017 IDLE: req_ready_o=1, rsp_valid_o=0, busy_o=0.
REQ-018 WAIT: req_ready_o=0, rsp_valid_o=0, busy_o=1.
REQ-019 RESP: req_ready_o=0, rsp_valid_o=1, busy_o=1.
REQ-020 SHALL accept a request on the rising edge where req_valid_i=1 and the FSM is in IDLE, and SHALL register write, addr, wdata and be at that edge.
REQ-021 After the accept edge, LATENCY=1 SHALL go directly to RESP; LATENCY>1 SHALL go to WAIT with a 4-bit down-counter loaded with LATENCY-2.
REQ-022 WAIT SHALL go to RESP on the edge where the counter equals 0; otherwise the counter SHALL decrement.
REQ-023 rsp_valid_o SHALL rise exactly LATENCY cycles after the accept edge.
REQ-024 SHALL perform the memory access, read capture or byte-enabled write, only on the edge that enters RESP.
REQ-025 On a write, only lanes with be=1 SHALL change; a write with be=0000 SHALL be a legal no-op acknowledge.
REQ-026 The word index SHALL be addr[31:2].
REQ-027 An error SHALL be flagged when addr[1:0]!=0 or the word index >= DEPTH; an error SHALL block the memory access and set rsp_err_o=1 and rsp_rdata_o=0.
REQ-028 For a write response, rsp_rdata_o SHALL be 0.
REQ-029 rsp_rdata_o and rsp_err_o SHALL be registered and stable throughout RESP.
REQ-030 RESP SHALL hold until rsp_ready_i=1, then return to IDLE on that edge; no back-to-back accept SHALL occur in the same edge.
REQ-031 When req_valid_i=1 during WAIT or RESP, the request SHALL be ignored; the requester holds it until req_ready_o=1.
REQ-032 In IDLE, rsp_ready_i SHALL be ignored.
REQ-033 A read following a write to the same word SHALL return the written data; there is no stale data path.

Reset
REQ-034 When rst_i=0, the FSM SHALL go to IDLE and the counter SHALL be 0.
REQ-035 During reset, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, busy_o=0 and req_ready_o=1 once reset is released.
REQ-036 Reset SHALL clear all DEPTH memory words to 0.
REQ-037 A reset in WAIT or RESP SHALL discard the pending request; a write that has not reached its RESP-entry edge SHALL never be performed.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, LATENCY_MIN=1, LATENCY_MAX=15 and the counter width of 4.
REQ-039 SHALL contain one sub-module, dmem_word_array: a DEPTH x 32 register array with async-low clear, a registered byte-enabled write port and a combinational read port.
REQ-040 Elaboration SHALL fail when LATENCY is outside 1..15.

Verification
REQ-041 With LATENCY=2, write addr 0x10, data 0xDEADBEEF, be=1111, rsp_ready_i held 1: rsp_valid_o rises 2 cycles after accept with err=0; then a read of 0x10 returns 0xDEADBEEF.
REQ-042 Partial write: word 0x10 holds 0xDEADBEEF; write 0x000000AA with be=0001; a read returns 0xDEADBEAA.
REQ-043 Errors: a read of addr 0x13 gives err=1, rdata=0; a write to 0x200 (index 128 with DEPTH=128) gives err=1 and no word changes.
REQ-044 Backpressure: rsp_ready_i=0 for 5 cycles in RESP gives rsp_valid_o=1 with stable data and req_ready_o=0 despite req_valid_i=1; the new request is accepted only after the handshake cycle.
REQ-045 Reset mid-operation: with LATENCY=4, write 0x55 to 0x20 and assert rst_i=0 in the 2nd WAIT cycle; a later read of 0x20 returns 0 and outputs match the reset values.
REQ-046 With LATENCY=1 and LATENCY=15, a request gives rsp_valid_o exactly 1 and 15 cycles after the accept edge respectively.
